// File: rtl/sram_read_sequencer_if.sv
// Bundles the command, SRAM read port and output stream signals of the read sequencer.
// Ports: start/base_addr/length command, busy/done status, sram_ren/sram_raddr/sram_rdata,
//        out_data/out_valid/out_ready/out_last stream. master = sequencer, slave = environment.
interface sram_read_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic              busy;
  logic              done;
  logic              sram_ren;
  logic [ADDR_W-1:0] sram_raddr;
  logic [DATA_W-1:0] sram_rdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    input  start, base_addr, length, sram_rdata, out_ready,
    output busy, done, sram_ren, sram_raddr, out_data, out_valid, out_last
  );

  modport slave (
    output start, base_addr, length, sram_rdata, out_ready,
    input  busy, done, sram_ren, sram_raddr, out_data, out_valid, out_last
  );
endinterface

// File: rtl/sram_read_sequencer.sv
// Streams a block of SRAM words out on a valid/ready stream, flagging the last beat.
// Latency: first read 1 cycle after start, first beat RD_LAT+2 cycles after start.
// Backpressure: reads are credit-limited so the output FIFO absorbs any out_ready stall.
// Ports: clk, rst (async, active-high), bus (sram_read_sequencer_if.master).
module sram_read_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  sram_read_sequencer_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ren_q, ren_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [ADDR_W:0]   issue_left_q, issue_left_d;  // reads still to issue after the current one
  logic [ADDR_W:0]   beats_left_q, beats_left_d;  // beats not yet handshaken
  logic [RD_LAT-1:0] pipe_q, pipe_d;              // reads in flight, tail = returning this cycle
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic       fifo_vld, push, pop, credit;
  logic [7:0] occ, occ_after;

  always_comb begin
    fifo_vld = (cnt_q != '0);
    push     = pipe_q[RD_LAT-1];
    pop      = fifo_vld && bus.out_ready;

    pipe_d[0] = ren_q;
    for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = bus.sram_rdata;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);

    // Every word that is issued, in flight, or buffered owns one FIFO slot.
    // A new read for next cycle is allowed only if a slot remains after this cycle's pop.
    occ = 8'(cnt_q) + 8'(ren_q);
    for (int i = 0; i < RD_LAT; i++) occ = occ + 8'(pipe_q[i]);
    occ_after = occ - 8'(pop);
    credit    = occ_after < 8'(FIFO_DEPTH);

    state_d      = state_q;
    done_d       = 1'b0;
    ren_d        = 1'b0;
    raddr_d      = raddr_q;
    issue_left_d = issue_left_q;
    beats_left_d = pop ? beats_left_q - LEN_ONE : beats_left_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.length == '0) begin
            done_d = 1'b1;
          end else begin
            state_d      = READ;
            ren_d        = 1'b1;
            raddr_d      = bus.base_addr;
            issue_left_d = bus.length - LEN_ONE;
            beats_left_d = bus.length;
          end
        end
      end
      READ: begin
        if (issue_left_q == '0) begin
          state_d = DRAIN;
        end else if (credit) begin
          ren_d        = 1'b1;
          raddr_d      = raddr_q + ADDR_W'(1);  // wraps modulo 2^ADDR_W
          issue_left_d = issue_left_q - LEN_ONE;
        end
      end
      default: ;
    endcase

    if (state_q != IDLE && pop && beats_left_q == LEN_ONE) begin
      done_d  = 1'b1;
      state_d = IDLE;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ren_q        <= 1'b0;
      raddr_q      <= '0;
      issue_left_q <= '0;
      beats_left_q <= '0;
      pipe_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ren_q        <= ren_d;
      raddr_q      <= raddr_d;
      issue_left_q <= issue_left_d;
      beats_left_q <= beats_left_d;
      pipe_q       <= pipe_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      mem_q        <= mem_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.sram_ren   = ren_q;
  assign bus.sram_raddr = raddr_q;
  assign bus.out_data   = mem_q[rd_ptr_q];
  assign bus.out_valid  = fifo_vld;
  assign bus.out_last   = fifo_vld && (beats_left_q == LEN_ONE);
endmodule
